// File: rtl/set_reset_sequencer_if.sv
// rtl/set_reset_sequencer_if.sv - command, response and downstream-register signal bundle

interface set_reset_sequencer_if #(
    parameter int ERR_CNT_W = 8
);
    logic                 CMD_VALID;
    logic                 CMD_READY;
    logic [1:0]           CMD_OP;
    logic                 CMD_DATA;
    logic                 REG_D;
    logic                 REG_S;
    logic                 REG_R;
    logic                 Q_FB;
    logic                 QN_FB;
    logic                 RSP_VALID;
    logic                 RSP_READY;
    logic                 RSP_ERR;
    logic                 RSP_Q;
    logic [ERR_CNT_W-1:0] ERR_CNT;

    // Sequencer side
    modport slave (
        input  CMD_VALID, CMD_OP, CMD_DATA, Q_FB, QN_FB, RSP_READY,
        output CMD_READY, REG_D, REG_S, REG_R, RSP_VALID, RSP_ERR, RSP_Q, ERR_CNT
    );

    // Command issuer / downstream register side
    modport master (
        output CMD_VALID, CMD_OP, CMD_DATA, Q_FB, QN_FB, RSP_READY,
        input  CMD_READY, REG_D, REG_S, REG_R, RSP_VALID, RSP_ERR, RSP_Q, ERR_CNT
    );
endinterface

// File: rtl/set_reset_sequencer.sv
// rtl/set_reset_sequencer.sv - drives a downstream set/reset flop per command and checks its readback

module set_reset_sequencer #(
    parameter int HOLD_CYCLES = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic CLK,
    input  logic R,
    set_reset_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b11;

    localparam logic [3:0]           HOLD_INIT = 4'(HOLD_CYCLES);
    localparam logic [ERR_CNT_W-1:0] CNT_MAX   = {ERR_CNT_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0] CNT_ONE   = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    // Drive pattern {REG_R, REG_S, REG_D} while an operation is being applied
    function automatic logic [2:0] apply_drive(input logic [1:0] op, input logic data);
        logic [2:0] drv;
        case (op)
            OP_CLEAR: drv = 3'b010;
            OP_SET:   drv = 3'b101;
            default:  drv = {2'b11, data};
        endcase
        return drv;
    endfunction

    // Value the downstream Q must show once the operation has been applied
    function automatic logic expected_for(input logic [1:0] op, input logic data);
        logic e;
        case (op)
            OP_SET:   e = 1'b1;
            OP_WRITE: e = data;
            default:  e = 1'b0;
        endcase
        return e;
    endfunction

    state_t               state_q, state_d;
    logic [3:0]           hold_q, hold_d;
    logic [1:0]           op_q, op_d;
    logic                 exp_q, exp_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 reg_r_q, reg_r_d;
    logic                 reg_s_q, reg_s_d;
    logic                 reg_d_q, reg_d_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 rsp_q_q, rsp_q_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic accept;
    logic accept_exp;

    assign accept     = cmd_ready_q && bus.CMD_VALID;
    assign accept_exp = expected_for(bus.CMD_OP, bus.CMD_DATA);

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        op_d        = op_q;
        exp_d       = exp_q;
        cmd_ready_d = 1'b0;
        reg_r_d     = 1'b1;
        reg_s_d     = 1'b1;
        reg_d_d     = bus.Q_FB;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_q_d     = rsp_q_q;
        err_cnt_d   = err_cnt_q;

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (accept) begin
                    cmd_ready_d = 1'b0;
                    op_d        = bus.CMD_OP;
                    exp_d       = accept_exp;
                    if (bus.CMD_OP == OP_NOP) begin
                        // NOP has nothing to apply; one CHECK cycle gives it
                        // its single-cycle response latency.
                        state_d = CHECK;
                        hold_d  = 4'd0;
                    end else begin
                        state_d = APPLY;
                        hold_d  = HOLD_INIT;
                        {reg_r_d, reg_s_d, reg_d_d} = apply_drive(bus.CMD_OP, bus.CMD_DATA);
                    end
                end
            end

            APPLY: begin
                if (hold_q <= 4'd1) begin
                    state_d = CHECK;
                    hold_d  = 4'd0;
                    reg_d_d = exp_q;
                end else begin
                    hold_d = hold_q - 4'd1;
                    {reg_r_d, reg_s_d, reg_d_d} = apply_drive(op_q, exp_q);
                end
            end

            CHECK: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_q_d     = bus.Q_FB;
                if (op_q == OP_NOP) begin
                    rsp_err_d = 1'b0;
                end else begin
                    rsp_err_d = (bus.Q_FB != exp_q) || (bus.QN_FB != ~bus.Q_FB);
                end
            end

            RESP: begin
                if (rsp_valid_q && bus.RSP_READY) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    if (rsp_err_q && (err_cnt_q != CNT_MAX)) begin
                        err_cnt_d = err_cnt_q + CNT_ONE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any command in flight
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state_q     <= IDLE;
            hold_q      <= 4'd0;
            op_q        <= OP_NOP;
            exp_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            reg_r_q     <= 1'b0;
            reg_s_q     <= 1'b1;
            reg_d_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_q_q     <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            op_q        <= op_d;
            exp_q       <= exp_d;
            cmd_ready_q <= cmd_ready_d;
            reg_r_q     <= reg_r_d;
            reg_s_q     <= reg_s_d;
            reg_d_q     <= reg_d_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_q_q     <= rsp_q_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.CMD_READY = cmd_ready_q;
    assign bus.REG_R     = reg_r_q;
    assign bus.REG_S     = reg_s_q;
    assign bus.REG_D     = reg_d_q;
    assign bus.RSP_VALID = rsp_valid_q;
    assign bus.RSP_ERR   = rsp_err_q;
    assign bus.RSP_Q     = rsp_q_q;
    assign bus.ERR_CNT   = err_cnt_q;

endmodule

// File: tb/tb_set_reset_sequencer.sv
// tb/tb_set_reset_sequencer.sv - directed self-checking bench for set_reset_sequencer

module tb_set_reset_sequencer;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b11;

    logic CLK = 1'b0;
    logic R;
    logic force_q0    = 1'b0;
    logic force_qn_eq = 1'b0;
    logic q_model;
    int   checks = 0;
    int   errors = 0;

    set_reset_sequencer_if #(.ERR_CNT_W(2)) bus ();

    set_reset_sequencer #(
        .HOLD_CYCLES(2),
        .ERR_CNT_W  (2)
    ) dut (
        .CLK(CLK),
        .R  (R),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    // Ideal downstream flop: sync active-low reset beats sync active-low set
    always @(posedge CLK) begin
        if (!bus.REG_R)      q_model <= 1'b0;
        else if (!bus.REG_S) q_model <= 1'b1;
        else                 q_model <= bus.REG_D;
    end

    assign bus.Q_FB  = force_q0 ? 1'b0 : q_model;
    assign bus.QN_FB = force_qn_eq ? bus.Q_FB : ~bus.Q_FB;

    task automatic run_cmd(input logic [1:0] op, input logic d, output int lat, output int r_low,
                           output logic a_s, output logic a_d, output logic r_err, output logic r_q);
        int w;
        w = 0;
        while (bus.CMD_READY !== 1'b1 && w < 20) begin
            @(negedge CLK);
            w++;
        end
        checks++;
        if (bus.CMD_READY !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ready_wait: CMD_READY=%b required 1", bus.CMD_READY);
        end
        bus.CMD_VALID = 1'b1;
        bus.CMD_OP    = op;
        bus.CMD_DATA  = d;
        @(negedge CLK);
        bus.CMD_VALID = 1'b0;
        bus.CMD_OP    = OP_NOP;
        bus.CMD_DATA  = 1'b0;
        a_s   = bus.REG_S;
        a_d   = bus.REG_D;
        lat   = 0;
        r_low = 0;
        while (bus.RSP_VALID !== 1'b1 && lat < 20) begin
            if (bus.REG_R === 1'b0) r_low++;
            @(negedge CLK);
            lat++;
        end
        r_err = bus.RSP_ERR;
        r_q   = bus.RSP_Q;
    endtask

    task automatic test_reset();
        R             = 1'b0;
        bus.CMD_VALID = 1'b1;
        bus.CMD_OP    = OP_SET;
        bus.CMD_DATA  = 1'b0;
        bus.RSP_READY = 1'b0;
        repeat (2) @(negedge CLK);
        checks++; if (bus.CMD_READY !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %b want 0", bus.CMD_READY); end
        checks++; if (bus.REG_R !== 1'b0) begin errors++; $display("FAIL rst_reg_r: got %b want 0", bus.REG_R); end
        checks++; if (bus.REG_S !== 1'b1) begin errors++; $display("FAIL rst_reg_s: got %b want 1", bus.REG_S); end
        checks++; if (bus.REG_D !== 1'b0) begin errors++; $display("FAIL rst_reg_d: got %b want 0", bus.REG_D); end
        checks++; if (bus.RSP_VALID !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", bus.RSP_VALID); end
        checks++; if (bus.RSP_ERR !== 1'b0) begin errors++; $display("FAIL rst_rsp_err: got %b want 0", bus.RSP_ERR); end
        checks++; if (bus.RSP_Q !== 1'b0) begin errors++; $display("FAIL rst_rsp_q: got %b want 0", bus.RSP_Q); end
        checks++; if (bus.ERR_CNT !== 2'd0) begin errors++; $display("FAIL rst_err_cnt: got %0d want 0", bus.ERR_CNT); end
        R = 1'b1;
        @(negedge CLK);
        checks++; if (bus.REG_R !== 1'b1) begin errors++; $display("FAIL rel_reg_r: got %b want 1", bus.REG_R); end
        checks++; if (bus.CMD_READY !== 1'b1) begin errors++; $display("FAIL rel_no_accept: CMD_READY=%b want 1", bus.CMD_READY); end
        bus.CMD_VALID = 1'b0;
        @(negedge CLK);
        checks++; if (bus.CMD_READY !== 1'b1) begin errors++; $display("FAIL rel_idle: CMD_READY=%b want 1", bus.CMD_READY); end
    endtask

    task automatic test_clear();
        int lat, rl;
        logic as_, ad, re, rq;
        bus.RSP_READY = 1'b1;
        run_cmd(OP_CLEAR, 1'b0, lat, rl, as_, ad, re, rq);
        checks++; if (lat !== 3) begin errors++; $display("FAIL clear_latency: got %0d want 3", lat); end
        checks++; if (rl !== 2) begin errors++; $display("FAIL clear_reg_r_low: got %0d cycles want 2", rl); end
        checks++; if (as_ !== 1'b1 || ad !== 1'b0) begin errors++; $display("FAIL clear_drive: S=%b D=%b want S=1 D=0", as_, ad); end
        checks++; if (re !== 1'b0 || rq !== 1'b0) begin errors++; $display("FAIL clear_rsp: err=%b q=%b want err=0 q=0", re, rq); end
        @(negedge CLK);
        checks++; if (bus.RSP_VALID !== 1'b0 || bus.CMD_READY !== 1'b1) begin
            errors++; $display("FAIL clear_handshake: RSP_VALID=%b CMD_READY=%b want 0 1", bus.RSP_VALID, bus.CMD_READY);
        end
    endtask

    task automatic test_write();
        int lat, rl;
        logic as_, ad, re, rq;
        run_cmd(OP_WRITE, 1'b1, lat, rl, as_, ad, re, rq);
        checks++; if (ad !== 1'b1 || rq !== 1'b1 || re !== 1'b0) begin errors++; $display("FAIL write1: D=%b q=%b err=%b want 1 1 0", ad, rq, re); end
        @(negedge CLK);
        run_cmd(OP_WRITE, 1'b0, lat, rl, as_, ad, re, rq);
        checks++; if (ad !== 1'b0 || rq !== 1'b0 || re !== 1'b0) begin errors++; $display("FAIL write0: D=%b q=%b err=%b want 0 0 0", ad, rq, re); end
        @(negedge CLK);
        run_cmd(OP_SET, 1'b0, lat, rl, as_, ad, re, rq);
        checks++; if (as_ !== 1'b0 || rq !== 1'b1 || re !== 1'b0) begin errors++; $display("FAIL set: S=%b q=%b err=%b want 0 1 0", as_, rq, re); end
        @(negedge CLK);
        run_cmd(OP_NOP, 1'b0, lat, rl, as_, ad, re, rq);
        checks++; if (lat !== 1) begin errors++; $display("FAIL nop_latency: got %0d want 1", lat); end
        checks++; if (rq !== 1'b1 || re !== 1'b0) begin errors++; $display("FAIL nop_rsp: q=%b err=%b want 1 0", rq, re); end
        @(negedge CLK);
        checks++; if (bus.ERR_CNT !== 2'd0) begin errors++; $display("FAIL write_err_cnt: got %0d want 0", bus.ERR_CNT); end
    endtask

    task automatic test_errors();
        int lat, rl;
        logic as_, ad, re, rq;
        force_q0 = 1'b1;
        run_cmd(OP_SET, 1'b0, lat, rl, as_, ad, re, rq);
        checks++; if (re !== 1'b1 || rq !== 1'b0) begin errors++; $display("FAIL set_q_stuck0: err=%b q=%b want 1 0", re, rq); end
        @(negedge CLK);
        checks++; if (bus.ERR_CNT !== 2'd1) begin errors++; $display("FAIL err_cnt_1: got %0d want 1", bus.ERR_CNT); end
        force_q0    = 1'b0;
        force_qn_eq = 1'b1;
        run_cmd(OP_WRITE, 1'b1, lat, rl, as_, ad, re, rq);
        checks++; if (re !== 1'b1 || rq !== 1'b1) begin errors++; $display("FAIL qn_equal_q: err=%b q=%b want 1 1", re, rq); end
        @(negedge CLK);
        checks++; if (bus.ERR_CNT !== 2'd2) begin errors++; $display("FAIL err_cnt_2: got %0d want 2", bus.ERR_CNT); end
        force_qn_eq = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat, rl;
        logic as_, ad, re, rq;
        bus.RSP_READY = 1'b0;
        run_cmd(OP_WRITE, 1'b0, lat, rl, as_, ad, re, rq);
        checks++; if (lat !== 3 || rq !== 1'b0) begin errors++; $display("FAIL bp_first: lat=%0d q=%b want 3 0", lat, rq); end
        bus.CMD_VALID = 1'b1;
        bus.CMD_OP    = OP_SET;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            checks++;
            if (bus.RSP_VALID !== 1'b1 || bus.CMD_READY !== 1'b0 || bus.RSP_Q !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: RSP_VALID=%b CMD_READY=%b RSP_Q=%b want 1 0 0", i, bus.RSP_VALID, bus.CMD_READY, bus.RSP_Q);
            end
        end
        bus.RSP_READY = 1'b1;
        @(negedge CLK);
        checks++; if (bus.RSP_VALID !== 1'b0 || bus.CMD_READY !== 1'b1) begin
            errors++; $display("FAIL bp_release: RSP_VALID=%b CMD_READY=%b want 0 1", bus.RSP_VALID, bus.CMD_READY);
        end
        @(negedge CLK);
        checks++; if (bus.CMD_READY !== 1'b0) begin errors++; $display("FAIL bp_accept_next: CMD_READY=%b want 0", bus.CMD_READY); end
        bus.CMD_VALID = 1'b0;
        bus.CMD_OP    = OP_NOP;
        lat = 0;
        while (bus.RSP_VALID !== 1'b1 && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
        checks++; if (lat !== 3 || bus.RSP_Q !== 1'b1 || bus.RSP_ERR !== 1'b0) begin
            errors++; $display("FAIL bp_second: lat=%0d q=%b err=%b want 3 1 0", lat, bus.RSP_Q, bus.RSP_ERR);
        end
        @(negedge CLK);
        checks++; if (bus.ERR_CNT !== 2'd2) begin errors++; $display("FAIL bp_err_cnt: got %0d want 2", bus.ERR_CNT); end
    endtask

    task automatic test_abort();
        int seen;
        bus.RSP_READY = 1'b1;
        bus.CMD_VALID = 1'b1;
        bus.CMD_OP    = OP_SET;
        @(negedge CLK);
        bus.CMD_VALID = 1'b0;
        bus.CMD_OP    = OP_NOP;
        checks++; if (bus.REG_S !== 1'b0) begin errors++; $display("FAIL abort_in_apply: REG_S=%b want 0", bus.REG_S); end
        #1 R = 1'b0;
        #1;
        checks++; if (bus.REG_R !== 1'b0 || bus.REG_S !== 1'b1) begin errors++; $display("FAIL abort_drive: R=%b S=%b want 0 1", bus.REG_R, bus.REG_S); end
        checks++; if (bus.RSP_VALID !== 1'b0 || bus.CMD_READY !== 1'b0) begin
            errors++; $display("FAIL abort_outputs: RSP_VALID=%b CMD_READY=%b want 0 0", bus.RSP_VALID, bus.CMD_READY);
        end
        checks++; if (bus.ERR_CNT !== 2'd0) begin errors++; $display("FAIL abort_err_cnt: got %0d want 0", bus.ERR_CNT); end
        repeat (2) @(negedge CLK);
        R    = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge CLK);
            if (bus.RSP_VALID === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_resp: RSP_VALID high %0d cycles want 0", seen); end
    endtask

    task automatic test_saturate();
        int lat, rl;
        logic as_, ad, re, rq;
        logic [1:0] want;
        force_q0 = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            run_cmd(OP_SET, 1'b0, lat, rl, as_, ad, re, rq);
            @(negedge CLK);
            want = (i > 3) ? 2'd3 : 2'(i);
            checks++;
            if (re !== 1'b1 || bus.ERR_CNT !== want) begin
                errors++; $display("FAIL sat_cmd%0d: err=%b ERR_CNT=%0d want 1 %0d", i, re, bus.ERR_CNT, want);
            end
        end
        force_q0 = 1'b0;
    endtask

    initial begin
        bus.CMD_VALID = 1'b0;
        bus.CMD_OP    = OP_NOP;
        bus.CMD_DATA  = 1'b0;
        bus.RSP_READY = 1'b0;
        R             = 1'b0;
        test_reset();
        test_clear();
        test_write();
        test_errors();
        test_back_to_back();
        test_abort();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/set_reset_sequencer.md
SET_RESET_SEQUENCER -- requirements
Module: set_reset_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 2, number of cycles a command drive is held on REG_R/REG_S/REG_D; legal range 1..15.
REQ-002 Parameter ERR_CNT_W, default 8, width of the saturating error counter.
REQ-003 CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 R  input  1  reset; asynchronous, active-low.
REQ-005 CMD_VALID  input  1  command request.
REQ-006 CMD_READY  output  1  block accepts a command this cycle.
REQ-007 CMD_OP  input  2  operation: 00 NOP, 01 SET, 10 CLEAR, 11 WRITE.
REQ-008 CMD_DATA  input  1  value to write (WRITE only).
REQ-009 REG_D  output  1  data drive to downstream set/reset register.
REQ-010 REG_S  output  1  active-low synchronous set drive to downstream register.
REQ-011 REG_R  output  1  active-low synchronous reset drive to downstream register; it has priority over REG_S downstream.
REQ-012 Q_FB  input  1  downstream register Q.
REQ-013 QN_FB  input  1  downstream register QN.
REQ-014 RSP_VALID  output  1  response available.
REQ-015 RSP_READY  input  1  response consumed.
REQ-016 RSP_ERR  output  1  readback mismatch for this command.
REQ-017 RSP_Q  output  1  Q_FB value sampled in CHECK.
REQ-018 ERR_CNT  output  ERR_CNT_W  count of commands completed with RSP_ERR=1, saturating.

Function
REQ-019 All outputs SHALL be registered; states IDLE, APPLY, CHECK, RESP.
REQ-020 IDLE: CMD_READY=1, REG_R=1, REG_S=1, REG_D=Q_FB from the previous cycle, so the downstream register recirculates its value.
REQ-021 CMD_VALID&&CMD_READY at an edge SHALL capture CMD_OP/CMD_DATA; NOP goes to RESP, others go to APPLY with a hold counter loaded to HOLD_CYCLES.
REQ-022 CMD_READY SHALL be 0 in every state other than IDLE; CMD_* inputs are ignored there.
REQ-023 APPLY drive: CLEAR: REG_R=0, REG_S=1, REG_D=0; SET: REG_R=1, REG_S=0, REG_D=1; WRITE: REG_R=1, REG_S=1, REG_D=CMD_DATA.
REQ-024 APPLY SHALL last exactly HOLD_CYCLES cycles, then go to CHECK with REG_R=1, REG_S=1, REG_D=expected value.
REQ-025 Expected value: CLEAR 0, SET 1, WRITE captured data; NOP has no expectation.
REQ-026 CHECK (1 cycle): RSP_ERR = (Q_FB != expected) || (QN_FB != ~Q_FB); RSP_Q = Q_FB; for NOP, RSP_ERR=0 and RSP_Q=Q_FB when entering RESP.
REQ-027 RSP_VALID SHALL rise HOLD_CYCLES+1 cycles after the acceptance edge (1 cycle for NOP).
REQ-028 RESP: RSP_VALID=1, RSP_ERR/RSP_Q stable until RSP_VALID&&RSP_READY; then IDLE; RSP_READY may be low indefinitely.
REQ-029 Back-to-back: a new command SHALL be accepted no earlier than the cycle after the response handshake.
REQ-030 ERR_CNT SHALL increment by 1 on each response handshake with RSP_ERR=1 and hold at all-ones.
REQ-031 Hold counter width SHALL be 4 bits; no wrap occurs within the legal range.

Reset
REQ-032 While R=0: state IDLE, CMD_READY=0, REG_R=0, REG_S=1, REG_D=0, RSP_VALID=0, RSP_ERR=0, RSP_Q=0, ERR_CNT=0, hold counter 0.
REQ-033 First rising edge with R=1: REG_R=1, CMD_READY=1; no command is accepted at that edge.
REQ-034 R falling mid-command SHALL abort immediately to reset values; the aborted command produces no response and no ERR_CNT change.

Verification
REQ-035 Reset release, then CLEAR, RSP_READY=1, ideal register -> REG_R low 2 cycles, RSP_VALID 3 cycles after accept, RSP_ERR=0, RSP_Q=0.
REQ-036 WRITE data=1, then WRITE data=0 -> REG_D=1 then 0 during APPLY; RSP_Q=1 then 0; ERR_CNT=0.
REQ-037 SET with Q_FB forced 0 -> RSP_ERR=1, ERR_CNT=1; with QN_FB forced equal to Q_FB -> RSP_ERR=1.
REQ-038 RSP_READY=0 for 10 cycles with CMD_VALID=1 -> RSP_VALID held, CMD_READY=0, no second acceptance; accept 1 cycle after handshake.
REQ-039 R asserted in APPLY cycle 1 -> REG_R=0, RSP_VALID=0 immediately; no response after release.
REQ-040 ERR_CNT_W=2, 5 erroneous commands -> ERR_CNT=3 after 3rd and stays 3.
